// File: rtl/mnist_pixel_streamer.sv
// Host-side driver for the MNIST core: buffers one 8-bit image, resets the core,
// streams every pixel as a fixed-point word, then waits for a digit or a timeout.
module mnist_pixel_streamer #(
  parameter int DATA_WIDTH = 24,
  parameter int FRAC_BITS  = 16,
  parameter int NUM_PIXELS = 784,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_PIXELS)-1:0] wr_addr,
  input  logic [7:0]                    wr_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [3:0]                    result,
  output logic                          timed_out,
  output logic                          core_rst,
  output logic                          core_valid,
  output logic [DATA_WIDTH-1:0]         core_pixel,
  input  logic                          core_o_valid,
  input  logic [3:0]                    core_digit
);

  localparam int AW = $clog2(NUM_PIXELS);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT, DONE} state_t;

  state_t          state_r, state_s;
  logic [AW-1:0]   pix_cnt_r, pix_cnt_s;
  logic [TW-1:0]   tmo_cnt_r, tmo_cnt_s;
  logic [3:0]      result_r, result_s;
  logic            timed_out_r, timed_out_s;
  logic            busy_r, done_r, core_rst_r, core_valid_r;
  logic [7:0]      mem_r [NUM_PIXELS];
  logic [7:0]      rd_data_r;
  logic            rd_en_s;
  logic [AW-1:0]   rd_addr_s;
  logic            wr_ok_s;
  logic            last_pix_s;

  // p/256 in the core's format: the byte lands just below the binary point
  function automatic logic [DATA_WIDTH-1:0] to_fixed(input logic [7:0] p);
    return DATA_WIDTH'(p) << (FRAC_BITS - 8);
  endfunction

  assign wr_ok_s    = wr_en && !busy_r && ({1'b0, wr_addr} < (AW+1)'(NUM_PIXELS));
  assign last_pix_s = (pix_cnt_r == AW'(NUM_PIXELS - 1));

  // Image buffer write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register returns to zero whenever no read is issued, so it idles at 0 with core_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= 8'd0;
    end else if (rd_en_s) begin
      rd_data_r <= mem_r[rd_addr_s];
    end else begin
      rd_data_r <= 8'd0;
    end
  end

  // Next-state, counter and result logic
  always_comb begin
    state_s     = state_r;
    pix_cnt_s   = pix_cnt_r;
    tmo_cnt_s   = tmo_cnt_r;
    result_s    = result_r;
    timed_out_s = timed_out_r;
    rd_en_s     = 1'b0;
    rd_addr_s   = '0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        rd_en_s   = 1'b1;
        rd_addr_s = '0;
        pix_cnt_s = '0;
        state_s   = STREAM;
      end
      STREAM: begin
        if (last_pix_s) begin
          tmo_cnt_s = '0;
          state_s   = WAIT;
        end else begin
          rd_en_s   = 1'b1;
          rd_addr_s = pix_cnt_r + AW'(1);
          pix_cnt_s = pix_cnt_r + AW'(1);
        end
      end
      WAIT: begin
        // A response on the limit cycle still counts as a real result
        if (core_o_valid) begin
          result_s    = core_digit;
          timed_out_s = 1'b0;
          state_s     = DONE;
        end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
          result_s    = 4'hF;
          timed_out_s = 1'b1;
          state_s     = DONE;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TW'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs, all decoded from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      pix_cnt_r    <= '0;
      tmo_cnt_r    <= '0;
      result_r     <= 4'd0;
      timed_out_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      core_rst_r   <= 1'b0;
      core_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pix_cnt_r    <= pix_cnt_s;
      tmo_cnt_r    <= tmo_cnt_s;
      result_r     <= result_s;
      timed_out_r  <= timed_out_s;
      busy_r       <= (state_s != IDLE);
      done_r       <= (state_s == DONE);
      core_rst_r   <= (state_s == CLEAR);
      core_valid_r <= (state_s == STREAM);
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign result     = result_r;
  assign timed_out  = timed_out_r;
  assign core_rst   = core_rst_r;
  assign core_valid = core_valid_r;
  assign core_pixel = to_fixed(rd_data_r);

endmodule
